// File: rtl/pkt_snapper.sv
// pkt_snapper
//   Truncates each AXI4-Stream packet to a byte-granular snap length and
//   optionally appends an XOR-fold hash of the dropped bytes right after the
//   last kept byte. The hash spills into one extra beat when it does not fit.
//   The length field in tuser[15:0] is rewritten for cut packets.
//
// Ports
//   axi_aclk, axi_reset        : clock, synchronous active-high reset
//   s_axis_t*                  : input stream (tready = FIFO not nearly full)
//   m_axis_t*                  : output stream
//   cut_en, cut_bytes, hash_en : configuration, latched per packet at FIFO head
//   cut_pkt_count              : number of packets cut (wraps)
module pkt_snapper #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int HASH_WIDTH           = 128,
  parameter int FIFO_DEPTH_BITS      = 3
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic                              cut_en,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     cut_bytes,
  input  logic                              hash_en,
  output logic [31:0]                       cut_pkt_count
);

  localparam int DATA_W = C_M_AXIS_DATA_WIDTH;
  localparam int BYTES  = DATA_W / 8;
  localparam int HB     = HASH_WIDTH / 8;
  localparam int NCHUNK = DATA_W / HASH_WIDTH;
  localparam int BW     = $clog2(BYTES);
  localparam int RW     = BW + 1;
  localparam int UW     = C_M_AXIS_TUSER_WIDTH;
  localparam int CW     = C_S_AXI_DATA_WIDTH;
  localparam int FDB    = FIFO_DEPTH_BITS;
  localparam int DEPTH  = 1 << FDB;
  localparam logic [FDB:0] NF_LVL = (FDB + 1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PASS, ST_HEAD, ST_DRAIN, ST_EMIT, ST_SPILL
  } state_t;

  // Byte-lane mask with lanes [0, n) set.
  function automatic logic [BYTES-1:0] low_mask(input int n);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) m[i] = (i < n);
    return m;
  endfunction

  // Expand a byte-lane mask to a bit mask.
  function automatic logic [DATA_W-1:0] lane_bits(input logic [BYTES-1:0] m);
    logic [DATA_W-1:0] b;
    for (int i = 0; i < BYTES; i++) b[8*i +: 8] = {8{m[i]}};
    return b;
  endfunction

  // ---------------------------------------------------------------
  // Input fallthrough FIFO
  // ---------------------------------------------------------------
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [BYTES-1:0]  fifo_strb [DEPTH];
  logic [UW-1:0]     fifo_user [DEPTH];
  logic              fifo_last [DEPTH];
  logic [FDB:0]      wr_ptr, rd_ptr, fifo_cnt;
  logic              empty, nearly_full, push, pop;

  logic [DATA_W-1:0] h_data;
  logic [BYTES-1:0]  h_strb;
  logic [UW-1:0]     h_user;
  logic              h_last;

  assign fifo_cnt      = wr_ptr - rd_ptr;
  assign empty         = (fifo_cnt == '0);
  assign nearly_full   = (fifo_cnt >= NF_LVL);
  assign s_axis_tready = !nearly_full && !axi_reset;
  assign push          = s_axis_tvalid && s_axis_tready;

  assign h_data = fifo_data[rd_ptr[FDB-1:0]];
  assign h_strb = fifo_strb[rd_ptr[FDB-1:0]];
  assign h_user = fifo_user[rd_ptr[FDB-1:0]];
  assign h_last = fifo_last[rd_ptr[FDB-1:0]];

  always_ff @(posedge axi_aclk) begin
    if (push) begin
      fifo_data[wr_ptr[FDB-1:0]] <= s_axis_tdata;
      fifo_strb[wr_ptr[FDB-1:0]] <= s_axis_tstrb;
      fifo_user[wr_ptr[FDB-1:0]] <= s_axis_tuser;
      fifo_last[wr_ptr[FDB-1:0]] <= s_axis_tlast;
    end
  end

  // ---------------------------------------------------------------
  // Per-packet cut decision from the head beat
  // ---------------------------------------------------------------
  logic [CW:0]   e_full, l_ext;
  logic [CW-1:0] s_m1;
  logic          cut_now;
  logic [RW-1:0] r_now;

  assign e_full  = {1'b0, cut_bytes} + (hash_en ? (CW + 1)'(HB) : '0);
  assign l_ext   = (CW + 1)'(h_user[15:0]);
  assign cut_now = cut_en && (cut_bytes != '0) && (l_ext > e_full);
  assign s_m1    = cut_bytes - CW'(1);
  // R = S - K*BYTES lies in 1..BYTES, i.e. ((S-1) mod BYTES) + 1.
  assign r_now   = {1'b0, s_m1[BW-1:0]} + RW'(1);

  // Latched per-packet configuration
  logic          cut_r, hash_r;
  logic [15:0]   k_r, e_r, beat_cnt;
  logic [RW-1:0] r_r;
  logic [UW-1:0] user_r;
  logic [DATA_W-1:0] hold_data;
  int            r_int;

  assign r_int = int'(r_r);

  // ---------------------------------------------------------------
  // Hash fold and boundary/spill beat assembly
  // ---------------------------------------------------------------
  logic [DATA_W-1:0]     acc;
  logic [HASH_WIDTH-1:0] hash_val;
  logic [DATA_W-1:0]     emit_data, spill_data;
  logic                  spill_needed;

  always_comb begin
    hash_val = '0;
    for (int c = 0; c < NCHUNK; c++) hash_val = hash_val ^ acc[c*HASH_WIDTH +: HASH_WIDTH];
  end

  always_comb begin
    emit_data  = hold_data;
    spill_data = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (hash_r && (i >= r_int) && (i < r_int + HB))
        emit_data[8*i +: 8] = hash_val[8*(i - r_int) +: 8];
      if (BYTES - r_int + i < HB)
        spill_data[8*i +: 8] = hash_val[8*(BYTES - r_int + i) +: 8];
    end
  end

  assign spill_needed = hash_r && (r_int + HB > BYTES);

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  state_t            state, state_n;
  logic              cfg_load, hold_load, acc_xor, beat_inc, cnt_inc;
  logic              out_vld, out_last;
  logic [DATA_W-1:0] out_data;
  logic [BYTES-1:0]  out_strb;
  logic [UW-1:0]     out_user;

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    cfg_load  = 1'b0;
    hold_load = 1'b0;
    acc_xor   = 1'b0;
    beat_inc  = 1'b0;
    cnt_inc   = 1'b0;
    out_vld   = 1'b0;
    out_data  = h_data;
    out_strb  = h_strb;
    out_last  = h_last;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          cfg_load = 1'b1;
          state_n  = cut_now ? ST_HEAD : ST_PASS;
        end
      end
      ST_PASS: begin
        out_vld = !empty;
        if (!empty && m_axis_tready) begin
          pop = 1'b1;
          if (h_last) state_n = ST_IDLE;
        end
      end
      ST_HEAD: begin
        if (!empty) begin
          if (beat_cnt == k_r) begin
            // Boundary beat is taken off the stream, never forwarded directly.
            pop       = 1'b1;
            hold_load = 1'b1;
            state_n   = h_last ? ST_EMIT : ST_DRAIN;
          end else begin
            out_vld = 1'b1;
            if (m_axis_tready) begin
              pop      = 1'b1;
              beat_inc = 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (!empty) begin
          pop     = 1'b1;
          acc_xor = 1'b1;
          if (h_last) state_n = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_vld  = 1'b1;
        out_data = emit_data;
        if (spill_needed) begin
          out_strb = '1;
          out_last = 1'b0;
        end else begin
          out_strb = low_mask(r_int + (hash_r ? HB : 0));
          out_last = 1'b1;
        end
        if (m_axis_tready) begin
          state_n = spill_needed ? ST_SPILL : ST_IDLE;
          cnt_inc = !spill_needed;
        end
      end
      ST_SPILL: begin
        out_vld  = 1'b1;
        out_data = spill_data;
        out_strb = low_mask(r_int + HB - BYTES);
        out_last = 1'b1;
        if (m_axis_tready) begin
          state_n = ST_IDLE;
          cnt_inc = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    out_user = user_r;
    if (cut_r) out_user[15:0] = e_r;
  end

  assign m_axis_tvalid = out_vld && !axi_reset;
  assign m_axis_tdata  = out_data;
  assign m_axis_tstrb  = out_strb;
  assign m_axis_tlast  = out_last;
  assign m_axis_tuser  = out_user;

  // ---------------------------------------------------------------
  // Control registers (reset)
  // ---------------------------------------------------------------
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state         <= ST_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      acc           <= '0;
      cut_pkt_count <= '0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (cfg_load)
        acc <= '0;
      else if (hold_load)
        acc <= h_data & lane_bits(h_strb & ~low_mask(r_int));
      else if (acc_xor)
        acc <= acc ^ (h_data & lane_bits(h_strb));
      if (cnt_inc) cut_pkt_count <= cut_pkt_count + 32'd1;
    end
  end

  // ---------------------------------------------------------------
  // Data / configuration registers (no reset)
  // ---------------------------------------------------------------
  always_ff @(posedge axi_aclk) begin
    if (cfg_load) begin
      cut_r    <= cut_now;
      hash_r   <= hash_en;
      k_r      <= 16'(s_m1 >> BW);
      r_r      <= r_now;
      e_r      <= 16'(e_full);
      user_r   <= h_user;
      beat_cnt <= '0;
    end else if (beat_inc) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
    if (hold_load) hold_data <= h_data;
  end

endmodule

// File: tb/tb_pkt_snapper.sv
module tb_pkt_snapper;
  localparam int DW = 256;
  localparam int NB = 32;
  localparam int UW = 128;

  logic           axi_aclk = 1'b0;
  logic           axi_reset = 1'b1;
  logic [DW-1:0]  s_axis_tdata = '0;
  logic [NB-1:0]  s_axis_tstrb = '0;
  logic [UW-1:0]  s_axis_tuser = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tlast = 1'b0;
  logic           s_axis_tready;
  logic [DW-1:0]  m_axis_tdata;
  logic [NB-1:0]  m_axis_tstrb;
  logic [UW-1:0]  m_axis_tuser;
  logic           m_axis_tvalid;
  logic           m_axis_tlast;
  logic           m_axis_tready = 1'b1;
  logic           cut_en = 1'b0;
  logic [31:0]    cut_bytes = '0;
  logic           hash_en = 1'b0;
  logic [31:0]    cut_pkt_count;

  pkt_snapper dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .cut_en(cut_en), .cut_bytes(cut_bytes), .hash_en(hash_en), .cut_pkt_count(cut_pkt_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NB-1:0] strb;
    logic          last;
    logic [UW-1:0] user;
  } exp_t;

  exp_t          sb[$];
  int            n_total = 0;
  int            n_pass = 0;
  logic [31:0]   exp_cnt = '0;
  logic [7:0]    pkt [0:4095];
  logic [DW-1:0] mon_data[$];
  logic [NB-1:0] mon_strb[$];
  logic [15:0]   mon_len[$];
  bit            rdy_rand = 1'b0;

  function automatic logic [DW-1:0] bm(input logic [NB-1:0] s);
    logic [DW-1:0] b;
    for (int i = 0; i < NB; i++) b[8*i +: 8] = {8{s[i]}};
    return b;
  endfunction

  function automatic logic [NB-1:0] ms(input int i);
    return (i < mon_strb.size()) ? mon_strb[i] : '0;
  endfunction
  function automatic logic [15:0] ml(input int i);
    return (i < mon_len.size()) ? mon_len[i] : '0;
  endfunction
  function automatic logic [DW-1:0] md(input int i);
    return (i < mon_data.size()) ? mon_data[i] : '0;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h required %0h", name, act, req);
    else n_pass++;
  endtask

  // Output-side ready pattern
  initial forever begin
    @(posedge axi_aclk); #1;
    m_axis_tready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Monitor: scoreboard compare on every accepted beat, stability under stall
  logic          stall = 1'b0;
  logic [DW-1:0] st_data;
  logic [NB-1:0] st_strb;
  logic          st_last;
  logic [UW-1:0] st_user;
  always @(negedge axi_aclk) begin : mon
    exp_t e;
    if (axi_reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        n_total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== st_data || m_axis_tstrb !== st_strb ||
            m_axis_tlast !== st_last || m_axis_tuser !== st_user)
          $display("FAIL hold_stable: vld=%b strb=%h last=%b required vld=1 strb=%h last=%b",
                   m_axis_tvalid, m_axis_tstrb, m_axis_tlast, st_strb, st_last);
        else n_pass++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        mon_data.push_back(m_axis_tdata);
        mon_strb.push_back(m_axis_tstrb);
        mon_len.push_back(m_axis_tuser[15:0]);
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_beat: strb=%h last=%b required no beat", m_axis_tstrb, m_axis_tlast);
        end else begin
          e = sb.pop_front();
          if (((m_axis_tdata & bm(e.strb)) !== e.data) || m_axis_tstrb !== e.strb ||
              m_axis_tlast !== e.last || m_axis_tuser !== e.user)
            $display("FAIL beat: data=%h strb=%h last=%b len=%0d required data=%h strb=%h last=%b len=%0d",
                     m_axis_tdata & bm(e.strb), m_axis_tstrb, m_axis_tlast, m_axis_tuser[15:0],
                     e.data, e.strb, e.last, e.user[15:0]);
          else n_pass++;
        end
      end
      stall   = m_axis_tvalid && !m_axis_tready;
      st_data = m_axis_tdata;
      st_strb = m_axis_tstrb;
      st_last = m_axis_tlast;
      st_user = m_axis_tuser;
    end
  end

  // Byte-level reference model: builds the expected output byte stream and
  // slices it into beats.
  task automatic model_push(input int len, input bit ce, input int s, input bit he,
                            input logic [UW-1:0] user_in);
    int         e;
    bit         cut;
    logic [7:0] a [NB];
    logic [7:0] ob[$];
    exp_t       x;
    int         nb;
    logic [UW-1:0] user;
    user = user_in;
    e    = s + (he ? 16 : 0);
    cut  = ce && (s != 0) && (len > e);
    if (!cut) begin
      for (int i = 0; i < len; i++) ob.push_back(pkt[i]);
    end else begin
      for (int i = 0; i < s; i++) ob.push_back(pkt[i]);
      if (he) begin
        for (int i = 0; i < NB; i++) a[i] = 8'h00;
        for (int i = s; i < len; i++) a[i % NB] = a[i % NB] ^ pkt[i];
        for (int j = 0; j < 16; j++) ob.push_back(a[j] ^ a[j + 16]);
      end
      user[15:0] = 16'(e);
      exp_cnt    = exp_cnt + 32'd1;
    end
    nb = (ob.size() + NB - 1) / NB;
    for (int b = 0; b < nb; b++) begin
      x.data = '0;
      x.strb = '0;
      for (int i = 0; i < NB; i++)
        if (b*NB + i < ob.size()) begin
          x.data[8*i +: 8] = ob[b*NB + i];
          x.strb[i] = 1'b1;
        end
      x.last = (b == nb - 1);
      x.user = user;
      sb.push_back(x);
    end
  endtask

  task automatic send_pkt(input int len, input logic [UW-1:0] user, input int max_beats, input bit gaps);
    int nb;
    int lim;
    bit got;
    nb = (len + NB - 1) / NB;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      if (gaps)
        while ($urandom_range(1, 0) == 1) begin
          s_axis_tvalid = 1'b0;
          @(posedge axi_aclk); #1;
        end
      for (int i = 0; i < NB; i++) begin
        if (b*NB + i < len) begin
          s_axis_tdata[8*i +: 8] = pkt[b*NB + i];
          s_axis_tstrb[i] = 1'b1;
        end else begin
          s_axis_tdata[8*i +: 8] = 8'h00;
          s_axis_tstrb[i] = 1'b0;
        end
      end
      s_axis_tuser  = user;
      s_axis_tlast  = (b == nb - 1);
      s_axis_tvalid = 1'b1;
      got = 1'b0;
      lim = 0;
      while (!got) begin
        @(negedge axi_aclk); got = s_axis_tready;
        @(posedge axi_aclk); #1;
        lim++;
        if (!got && lim > 5000) begin
          $display("FAIL s_axis_tready: got 0 for 5000 cycles required 1");
          $fatal(1, "input stalled");
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int lim;
    lim = 0;
    while (sb.size() != 0 && lim < 20000) begin
      @(posedge axi_aclk); #1;
      lim++;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (3) begin @(posedge axi_aclk); #1; end
  endtask

  task automatic fill(input int len, input int mode, input logic [7:0] v);
    for (int i = 0; i < len; i++)
      pkt[i] = (mode == 0) ? v : (mode == 1) ? 8'(i) : 8'($urandom);
  endtask

  function automatic logic [UW-1:0] mk_user(input int len);
    logic [UW-1:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[15:0] = 16'(len);
    return u;
  endfunction

  task automatic clr_mon();
    mon_data.delete();
    mon_strb.delete();
    mon_len.delete();
  endtask

  task automatic run_pkt(input int len, input bit ce, input int s, input bit he, input bit gaps);
    logic [UW-1:0] u;
    u = mk_user(len);
    cut_en = ce; cut_bytes = 32'(s); hash_en = he;
    clr_mon();
    model_push(len, ce, s, he, u);
    send_pkt(len, u, 1000, gaps);
    wait_drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [UW-1:0] u;
    int len, s;
    bit ce, he;

    // Reset state
    repeat (2) @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_count", cut_pkt_count, 0);
    @(posedge axi_aclk); #1;
    axi_reset = 1'b0;
    repeat (2) begin @(posedge axi_aclk); #1; end
    chk("idle_m_tvalid", m_axis_tvalid, 0);

    // No cut
    fill(100, 1, 0);
    run_pkt(100, 0, 40, 1, 0);
    chk("t1_beats", mon_strb.size(), 4);
    chk("t1_last_strb", ms(3), 32'h0000000F);
    chk("t1_len", ml(3), 100);
    chk("t1_count", cut_pkt_count, 0);

    // Cut with hash in one beat
    fill(128, 0, 8'hA5);
    run_pkt(128, 1, 40, 1, 0);
    chk("t2_beats", mon_strb.size(), 2);
    chk("t2_strb", ms(1), 32'h00FFFFFF);
    chk("t2_len", ml(1), 56);
    chk("t2_kept", md(1)[63:0], {8{8'hA5}});
    chk("t2_hash", md(1)[191:64], {64'h0, {8{8'hA5}}});
    chk("t2_count", cut_pkt_count, 1);

    // Cut with spill, output backpressure
    rdy_rand = 1'b1;
    fill(200, 1, 0);
    run_pkt(200, 1, 60, 1, 1);
    rdy_rand = 1'b0;
    chk("t3_beats", mon_strb.size(), 3);
    chk("t3_b1_strb", ms(1), 32'hFFFFFFFF);
    chk("t3_b2_strb", ms(2), 32'h00000FFF);
    chk("t3_len", ml(2), 76);
    chk("t3_count", cut_pkt_count, 2);

    // Short packet: L == E
    fill(56, 2, 0);
    run_pkt(56, 1, 40, 1, 0);
    chk("t4_beats", mon_strb.size(), 2);
    chk("t4_strb", ms(1), 32'h00FFFFFF);
    chk("t4_len", ml(1), 56);
    chk("t4_count", cut_pkt_count, 2);

    // Cut without hash
    fill(65, 2, 0);
    run_pkt(65, 1, 64, 0, 0);
    chk("t5_beats", mon_strb.size(), 2);
    chk("t5_strb", ms(1), 32'hFFFFFFFF);
    chk("t5_len", ml(1), 64);
    chk("t5_count", cut_pkt_count, 3);

    // cut_bytes = 0 means no cut
    fill(90, 2, 0);
    run_pkt(90, 1, 0, 1, 0);
    chk("t6_len", ml(0), 90);
    chk("t6_count", cut_pkt_count, 3);

    // R == BYTES: hash goes entirely into the spill beat
    fill(100, 2, 0);
    run_pkt(100, 1, 32, 1, 0);
    chk("t7_beats", mon_strb.size(), 2);
    chk("t7_strb", ms(1), 32'h0000FFFF);

    // R + HB == BYTES: exactly one full final beat
    fill(100, 2, 0);
    run_pkt(100, 1, 16, 1, 0);
    chk("t8_beats", mon_strb.size(), 1);
    chk("t8_strb", ms(0), 32'hFFFFFFFF);
    chk("t8_count", cut_pkt_count, 5);

    // Stress: groups of back-to-back packets sharing one configuration
    rdy_rand = 1'b1;
    for (int g = 0; g < 125; g++) begin
      ce = ($urandom_range(3, 0) != 0);
      he = 1'($urandom_range(1, 0));
      s  = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(150, 1));
      cut_en = ce; cut_bytes = 32'(s); hash_en = he;
      for (int p = 0; p < 8; p++) begin
        len = int'($urandom_range(200, 1));
        fill(len, 2, 0);
        u = mk_user(len);
        model_push(len, ce, s, he, u);
        send_pkt(len, u, 1000, 1);
      end
      wait_drain();
    end
    rdy_rand = 1'b0;
    chk("stress_count", cut_pkt_count, exp_cnt);

    // Reset while draining the dropped tail
    fill(200, 1, 0);
    cut_en = 1'b1; cut_bytes = 32'd40; hash_en = 1'b1;
    u = mk_user(200);
    model_push(200, 1, 40, 1, u);
    send_pkt(200, u, 4, 0);
    repeat (4) begin @(posedge axi_aclk); #1; end
    axi_reset = 1'b1;
    @(negedge axi_aclk);
    chk("rst_mid_tvalid", m_axis_tvalid, 0);
    @(posedge axi_aclk); #1;
    axi_reset = 1'b0;
    sb.delete();
    @(negedge axi_aclk);
    chk("rst_after_tvalid", m_axis_tvalid, 0);
    chk("rst_after_count", cut_pkt_count, 0);
    @(posedge axi_aclk); #1;
    exp_cnt = '0;
    fill(128, 0, 8'hA5);
    run_pkt(128, 1, 40, 1, 0);
    chk("rst_next_beats", mon_strb.size(), 2);
    chk("rst_next_hash", md(1)[191:64], {64'h0, {8{8'hA5}}});
    chk("rst_next_count", cut_pkt_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
